// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage with a 2-entry in-order instruction FIFO.
//
// Issues fetch requests to instruction memory under a credit limit of two.
// The credit covers requests still in flight, responses that are due to be
// discarded, and FIFO entries. Responses are buffered with their fetch PC and
// presented to decode.
// A redirect flushes the FIFO, restarts fetch at the word-aligned target and
// arranges for every older response still in flight to be discarded.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   imem_req_valid/ready/addr     fetch request handshake and byte address
//   imem_rsp_valid/data           in-order instruction responses (no backpressure)
//   redirect, redirect_pc         redirect pulse and target from later stages
//   stall                         decode cannot consume this cycle
//   if_valid, if_instr, if_pc     FIFO head presented to decode
//   rs1_addr, rs2_addr            register file read addresses from if_instr
module ifetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr
);

    logic [WIDTH-1:0] r_pc;
    logic [31:0]      r_instr [2];
    logic [WIDTH-1:0] r_ipc   [2];
    logic             r_head;
    logic [1:0]       r_count;
    logic [1:0]       r_inflight;
    logic [1:0]       r_drop;

    logic [2:0]       w_used;
    logic             w_req_fire;
    logic             w_rsp_owned;
    logic             w_push;
    logic             w_pop;
    logic             w_tail;
    logic [WIDTH-1:0] w_rsp_pc;
    logic [2:0]       w_flush_sum;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [1:0]       w_inflight_nxt;
    logic [1:0]       w_drop_nxt;
    logic [1:0]       w_count_nxt;
    logic             w_head_nxt;

    // Credits: every request occupies one slot from issue until it is either
    // discarded or popped by decode, so the FIFO can never overflow.
    assign w_used         = {1'b0, r_inflight} + {1'b0, r_drop} + {1'b0, r_count};
    assign imem_req_valid = rst & ~redirect & (w_used < 3'd2);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // A response while the drop counter is zero belongs to the oldest live request.
    assign w_rsp_owned = imem_rsp_valid & (r_drop == 2'd0);
    assign w_push      = w_rsp_owned & ~redirect & (r_count != 2'd2);
    assign w_pop       = (r_count != 2'd0) & ~stall & ~redirect;
    assign w_tail      = r_head ^ r_count[0];

    // Live requests are contiguous words ending just below the PC, so the
    // oldest one sits r_inflight words back.
    assign w_rsp_pc = r_pc - WIDTH'({r_inflight, 2'b00});

    always_comb begin
        w_flush_sum    = {1'b0, r_inflight} + {1'b0, r_drop};
        w_pc_nxt       = r_pc;
        w_inflight_nxt = r_inflight;
        w_drop_nxt     = r_drop;
        w_count_nxt    = r_count;
        w_head_nxt     = r_head;
        if (redirect) begin
            // Everything still outstanding becomes a drop, less the response
            // consumed on this same edge. No request can issue on a redirect edge.
            if (imem_rsp_valid && (w_flush_sum != 3'd0)) begin
                w_flush_sum = w_flush_sum - 3'd1;
            end
            w_pc_nxt       = redirect_pc & ~WIDTH'(3);
            w_inflight_nxt = 2'd0;
            w_drop_nxt     = w_flush_sum[1:0];
            w_count_nxt    = 2'd0;
            w_head_nxt     = 1'b0;
        end else begin
            if (w_req_fire) begin
                w_pc_nxt = r_pc + WIDTH'(4);
            end
            if (imem_rsp_valid && (r_drop != 2'd0)) begin
                w_drop_nxt = r_drop - 2'd1;
            end
            w_inflight_nxt = r_inflight + {1'b0, w_req_fire} - {1'b0, w_rsp_owned};
            w_count_nxt    = r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                w_head_nxt = ~r_head;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
            r_inflight <= 2'd0;
            r_drop     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= '0;
                r_ipc[i]   <= '0;
            end
        end else begin
            r_pc       <= w_pc_nxt;
            r_head     <= w_head_nxt;
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            r_drop     <= w_drop_nxt;
            if (w_push) begin
                r_instr[w_tail] <= imem_rsp_data;
                r_ipc[w_tail]   <= w_rsp_pc;
            end
        end
    end

    assign if_valid = (r_count != 2'd0);
    assign if_instr = r_instr[r_head];
    assign if_pc    = r_ipc[r_head];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order memory model with configurable latency, a
// scoreboard of expected {pc, instr} pushed on request acceptance and popped
// when decode consumes, a vector table of redirect targets, and directed
// sequences for stall, backpressure, redirect-drop and PC wrap.
module tb_ifetch_unit;
    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    always #5 clk = ~clk;

    ifetch_unit #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=none required=event", name);
    endtask

    // Instruction memory contents: a few fixed words, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0200: return 32'h00A2_8533;
            32'h0000_0304: return 32'hFFF0_0F93;
            32'h0000_0400: return 32'h01F7_87B3;
            default:       return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] mem_addr_q[$];
    time         mem_iss_q[$];
    int          mem_delay      = 1;
    int          max_out        = 0;
    int          fire_cnt       = 0;
    logic [31:0] last_fire_addr = '0;

    // Observer: all inputs change on negedges, so values read here are pre-edge.
    always @(posedge clk) begin
        if (!rst) begin
            mem_addr_q.delete();
            mem_iss_q.delete();
            sb_q.delete();
        end else begin
            if (if_valid && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    timeout("sb_unexpected_instr");
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_instr", if_instr, e.instr);
                end
            end
            if (imem_rsp_valid && mem_addr_q.size() != 0) begin
                void'(mem_addr_q.pop_front());
                void'(mem_iss_q.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mem_addr_q.push_back(imem_req_addr);
                mem_iss_q.push_back($time);
                if (mem_addr_q.size() > max_out) max_out = mem_addr_q.size();
                fire_cnt       <= fire_cnt + 1;
                last_fire_addr <= imem_req_addr;
            end
            if (redirect) begin
                sb_q.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                sb_q.push_back('{pc: imem_req_addr, instr: mem_word(imem_req_addr)});
            end
        end
    end

    // Memory model: answers the oldest request once mem_delay cycles have passed.
    always @(negedge clk) begin
        if (rst && mem_addr_q.size() != 0 &&
            ($time + 5 - mem_iss_q[0]) >= time'(10 * mem_delay)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_addr_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic do_redirect(input logic [31:0] target);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    task automatic wait_if_valid(input string name);
        int n = 0;
        while (!if_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!if_valid) timeout(name);
    endtask

    task automatic wait_fire(input string name);
        int n  = 0;
        int f0 = fire_cnt;
        while (fire_cnt == f0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (fire_cnt == f0) timeout(name);
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{target: 32'h203, exp_pc: 32'h200, exp_instr: 32'h00A2_8533,
                    exp_rs1: 5'd5,  exp_rs2: 5'd10};
        vecs[1] = '{target: 32'h305, exp_pc: 32'h304, exp_instr: 32'hFFF0_0F93,
                    exp_rs1: 5'd0,  exp_rs2: 5'd31};
        vecs[2] = '{target: 32'h402, exp_pc: 32'h400, exp_instr: 32'h01F7_87B3,
                    exp_rs1: 5'd15, exp_rs2: 5'd31};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_rs1", 32'(rs1_addr), 32'd0);
        chk("rst_rs2", 32'(rs2_addr), 32'd0);

        // First request right after release, then back-to-back
        rst = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        chk("second_req_valid", 32'(imem_req_valid), 32'd1);
        chk("second_req_addr", imem_req_addr, 32'h4);
        repeat (12) @(negedge clk);

        // Stall: FIFO fills, credits exhausted
        stall = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_outstanding", 32'(mem_addr_q.size()), 32'd0);
        chk("stall_sb_held", 32'(sb_q.size()), 32'd2);
        stall = 1'b0;
        repeat (6) @(negedge clk);

        // Backpressure: address holds at 0x8, then advances to 0xC
        imem_req_ready = 1'b0;
        do_redirect(32'h8);
        for (int i = 0; i < 3; i++) begin
            chk("hold_addr", imem_req_addr, 32'h8);
            @(negedge clk);
        end
        chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        wait_fire("hold_fire");
        chk("hold_fired_addr", last_fire_addr, 32'h8);
        chk("hold_next_addr", imem_req_addr, 32'hC);
        repeat (4) @(negedge clk);

        // Redirect vectors: alignment and register address decode
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            stall       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = vecs[v].target;
            @(negedge clk);
            redirect = 1'b0;
            wait_if_valid("vec_if_valid");
            chk("vec_if_pc", if_pc, vecs[v].exp_pc);
            chk("vec_if_instr", if_instr, vecs[v].exp_instr);
            chk("vec_rs1", 32'(rs1_addr), 32'(vecs[v].exp_rs1));
            chk("vec_rs2", 32'(rs2_addr), 32'(vecs[v].exp_rs2));
            stall = 1'b0;
        end
        repeat (4) @(negedge clk);

        // Two requests in flight (0x10, 0x14), redirect to 0x103 drops both
        mem_delay = 4;
        do_redirect(32'h10);
        begin
            int n = 0;
            while (!(mem_addr_q.size() == 2 && mem_addr_q[0] == 32'h10 &&
                     mem_addr_q[1] == 32'h14) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n == 40) timeout("drop_setup");
        end
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        chk("drop_req_blocked", 32'(imem_req_valid), 32'd0);
        wait_fire("drop_fire");
        chk("drop_first_addr", last_fire_addr, 32'h100);
        wait_if_valid("drop_if_valid");
        chk("drop_first_if_pc", if_pc, 32'h100);
        mem_delay = 1;
        repeat (6) @(negedge clk);

        // PC wrap-around
        do_redirect(32'hFFFF_FFFE);
        wait_fire("wrap_fire");
        chk("wrap_fired_addr", last_fire_addr, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_req_addr, 32'h0);
        repeat (6) @(negedge clk);

        // Drain: every accepted, non-flushed request must reach decode
        imem_req_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address/PC width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have port imem_req_valid, output, 1, fetch request valid.
REQ-006 The block SHALL have port imem_req_ready, input, 1, memory accepts request.
REQ-007 The block SHALL have port imem_req_addr, output, WIDTH, fetch byte address.
REQ-008 The block SHALL have port imem_rsp_valid, input, 1, instruction word returned.
REQ-009 The block SHALL have port imem_rsp_data, input, 32, returned instruction word.
REQ-010 The block SHALL have port redirect, input, 1, branch/jump redirect pulse from later stages.
REQ-011 The block SHALL have port redirect_pc, input, WIDTH, redirect target.
REQ-012 The block SHALL have port stall, input, 1, decode cannot consume this cycle.
REQ-013 The block SHALL have port if_valid, output, 1, if_instr/if_pc hold a valid instruction.
REQ-014 The block SHALL have port if_instr, output, 32, instruction to decode.
REQ-015 The block SHALL have port if_pc, output, WIDTH, byte address of if_instr.
REQ-016 The block SHALL have ports rs1_addr and rs2_addr, output, 5 each, equal to if_instr[19:15] and if_instr[24:20], driving the register file read addresses.

Function
REQ-017 The block SHALL hold a PC register, a 2-entry in-order instruction FIFO (instr + pc), an in-flight counter (0..2) and a drop counter (0..2).
REQ-018 imem_req_valid SHALL be 1 iff redirect=0 and in-flight + drop + FIFO occupancy < 2.
REQ-019 imem_req_addr SHALL equal PC; a request is accepted when imem_req_valid & imem_req_ready at a rising edge, then PC <= PC + 4 (mod 2^WIDTH, wrap-around allowed) and in-flight increments.
REQ-020 While imem_req_valid=1 and imem_req_ready=0, imem_req_addr SHALL stay stable.
REQ-021 Memory returns exactly one response per accepted request, in order, minimum 1 cycle after acceptance; the block SHALL accept imem_rsp_valid every cycle (no backpressure).
REQ-022 A response with drop counter = 0 SHALL be written to the FIFO tail with the PC of its request; in-flight decrements.
REQ-023 A response with drop counter > 0 SHALL be discarded and decrement the drop counter only.
REQ-024 if_valid SHALL be 1 iff FIFO non-empty; if_instr/if_pc SHALL show the FIFO head; head pops at an edge where if_valid=1 and stall=0.
REQ-025 Response-to-if_valid latency SHALL be 1 cycle (registered FIFO, no bypass); push and pop in the same cycle SHALL both take effect.
REQ-026 When redirect=1 at an edge: PC <= {redirect_pc[WIDTH-1:2], 2'b00}; FIFO flushed; drop <= in-flight + drop (+1 if a request was accepted that edge, +0 otherwise, noting REQ-018 blocks new issue), minus 1 if a response arrives that edge; in-flight <= 0.
REQ-027 A response arriving on a redirect edge SHALL never enter the FIFO.
REQ-028 redirect SHALL take priority over stall; a pop is suppressed on a redirect edge.
REQ-029 The credit rule (REQ-018) SHALL guarantee no FIFO overflow; the block SHALL not depend on memory behaviour for this.
REQ-030 Operating mode SHALL be FETCH when drop = 0 and FLUSH when drop > 0; in FLUSH, requests to the new PC may still issue under REQ-018.

Reset
REQ-031 While rst=0 (asynchronously): PC = RESET_PC, FIFO empty, in-flight = 0, drop = 0, imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc = 0, rs1_addr = rs2_addr = 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and in-flight state; responses to pre-reset requests are the memory model's responsibility to squash.
REQ-033 The first request SHALL be issued (addr = RESET_PC) on the first cycle after rst deasserts.

Verification
REQ-034 Reset release, ready=1, 1-cycle memory, stall=0 -> addresses 0,4,8,... issued back-to-back; if_pc sequence 0,4,8 with matching if_instr.
REQ-035 stall=1 for 5 cycles -> FIFO fills to 2, imem_req_valid=0 after 2 outstanding, no instruction lost or duplicated on release.
REQ-036 Two requests in flight (addr 0x10, 0x14), redirect to 0x103 -> both responses dropped, next request addr 0x100, first if_pc = 0x100.
REQ-037 imem_req_ready=0 for 3 cycles -> imem_req_addr stable at 0x8 throughout; acceptance then proceeds to 0xC.
REQ-038 Instruction 0x00A28533 delivered -> rs1_addr = 5, rs2_addr = 10 while if_valid=1.
REQ-039 PC = 0xFFFF_FFFC accepted -> next imem_req_addr = 0x0000_0000.
